// File: rtl/snake_pkg.sv
// Shared types and helpers for the LED-snake step controller.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned N_DEF     = 24;
  localparam int unsigned POS_W_DEF = 5;
  localparam int unsigned MOD_W     = 16;

  // (pos + delta) mod n for pos < n and delta <= n, using one extra bit and a
  // single conditional subtract so non-power-of-two rings wrap correctly.
  function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] pos,
                                               input logic [MOD_W-1:0] delta,
                                               input logic [MOD_W-1:0] n);
    logic [MOD_W:0] s;
    s = {1'b0, pos} + {1'b0, delta};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[MOD_W-1:0];
  endfunction

endpackage

// File: rtl/snake_step_ctrl_prescaler.sv
// Step prescaler: counts 0..STEP_DIV-1 while enabled, holds otherwise.
module step_prescaler #(
  parameter int unsigned STEP_DIV = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned   CW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  assign tick = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_step_ctrl.sv
// LED-snake controller: start/pause/stop FSM, head stepping, tail and mask.
module snake_step_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned N        = N_DEF,
  parameter int unsigned POS_W    = POS_W_DEF,
  parameter int unsigned STEP_DIV = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [POS_W-1:0] len_in,
  output logic [POS_W-1:0] head,
  output logic [POS_W-1:0] tail,
  output logic [N-1:0]     led_mask,
  output logic             step,
  output logic             lap,
  output logic             busy
);

  localparam logic [MOD_W-1:0] NW = MOD_W'(N);

  state_e           state_q, state_d;
  logic [POS_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [POS_W-1:0] len_m1_q, len_m1_d, len_m1_start, head_step;
  logic [N-1:0]     mask_q, mask_d;
  logic             dir_q, dir_d, step_q, step_d, lap_q, lap_d, busy_q, busy_d;
  logic             pre_en, pre_clr, tick;

  // Set every position whose ring distance from lo (incrementing) is <= len_m1.
  function automatic logic [N-1:0] span_mask(input logic [POS_W-1:0] lo,
                                             input logic [POS_W-1:0] len_m1);
    logic [N-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mod_add(MOD_W'(i), NW - MOD_W'(lo), NW) <= MOD_W'(len_m1)) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign pre_en  = (state_q == RUN) && !stop;
  assign pre_clr = ((state_q == IDLE) && start && !stop) || ((state_q == HOLD) && stop);

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign len_m1_start = (len_in == '0)                ? '0 :
                        (MOD_W'(len_in) > NW)         ? POS_W'(N - 1) :
                                                        len_in - POS_W'(1);
  assign head_step    = dir ? POS_W'(mod_add(MOD_W'(head_q), NW - MOD_W'(1), NW))
                            : POS_W'(mod_add(MOD_W'(head_q), MOD_W'(1), NW));

  always_comb begin
    state_d  = state_q;
    head_d   = head_q;
    dir_d    = dir_q;
    len_m1_d = len_m1_q;
    step_d   = 1'b0;
    lap_d    = 1'b0;
    unique case (state_q)
      IDLE: if (start && !stop) begin
        state_d  = RUN;
        len_m1_d = len_m1_start;
        head_d   = len_m1_start;
        dir_d    = 1'b0;
      end
      RUN: begin
        if (stop) state_d = HOLD;
        else if (tick) begin
          dir_d  = dir;
          head_d = head_step;
          step_d = 1'b1;
          lap_d  = dir ? (head_q == '0) : (head_q == POS_W'(N - 1));
        end
      end
      HOLD: begin
        if (stop)       state_d = IDLE;
        else if (start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    // Tail and mask are derived from the next head/dir so they land with it.
    if (state_d == IDLE) begin
      head_d = '0;
      dir_d  = 1'b0;
      tail_d = '0;
      mask_d = '0;
      busy_d = 1'b0;
    end else begin
      tail_d = dir_d ? POS_W'(mod_add(MOD_W'(head_d), MOD_W'(len_m1_d), NW))
                     : POS_W'(mod_add(MOD_W'(head_d), NW - MOD_W'(len_m1_d), NW));
      mask_d = span_mask(dir_d ? head_d : tail_d, len_m1_d);
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      tail_q   <= '0;
      len_m1_q <= '0;
      mask_q   <= '0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      lap_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      len_m1_q <= len_m1_d;
      mask_q   <= mask_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      lap_q    <= lap_d;
      busy_q   <= busy_d;
    end
  end

  assign head     = head_q;
  assign tail     = tail_q;
  assign led_mask = mask_q;
  assign step     = step_q;
  assign lap      = lap_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// Self-checking bench for snake_step_ctrl (N=24, STEP_DIV=4) against a ring model.
module tb_snake_step_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, stop = 1'b0, dir = 1'b0;
  logic [4:0]  len_in = '0;
  logic [4:0]  head, tail;
  logic [23:0] led_mask;
  logic        step, lap, busy;
  logic [36:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: mode 0=idle 1=run 2=hold; body walked from the head.
  int m_mode = 0, m_cnt = 0, m_head = 0, m_len = 1, m_dir = 0;
  bit m_step = 0, m_lap = 0;

  snake_step_ctrl #(.N(24), .POS_W(5), .STEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .len_in(len_in),
    .head(head), .tail(tail), .led_mask(led_mask), .step(step), .lap(lap), .busy(busy)
  );

  always #5 clk = ~clk;
  assign act = {head, tail, led_mask, step, lap, busy};

  function automatic logic [36:0] exp_vec();
    int t;
    logic [23:0] m;
    if (m_mode == 0) return '0;
    t = m_dir ? (m_head + m_len - 1) % 24 : (m_head - (m_len - 1) + 24) % 24;
    m = '0;
    for (int k = 0; k < m_len; k++) m[m_dir ? (m_head + k) % 24 : (m_head - k + 24) % 24] = 1'b1;
    return {5'(m_head), 5'(t), m, m_step, m_lap, 1'b1};
  endfunction

  task automatic model_update();
    m_step = 0;
    m_lap  = 0;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_head = 0;
    end else if (m_mode == 0) begin
      if (start && !stop) begin
        m_mode = 1;
        m_len  = (len_in == 0) ? 1 : (int'(len_in) > 24 ? 24 : int'(len_in));
        m_head = m_len - 1; m_dir = 0; m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (stop) m_mode = 2;
      else if (m_cnt == 3) begin
        m_cnt = 0; m_step = 1; m_dir = int'(dir);
        if (dir == 1'b0) begin m_lap = (m_head == 23); m_head = (m_head + 1) % 24; end
        else             begin m_lap = (m_head == 0);  m_head = (m_head + 23) % 24; end
      end else m_cnt++;
    end else begin
      if (stop) begin m_mode = 0; m_cnt = 0; m_head = 0; end
      else if (start) m_mode = 1;
    end
  endtask

  task automatic cyc();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    n_tests++;
    if (act !== 37'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", act); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (act !== 37'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", act); end
    end
  endtask

  task automatic test_start_forward();
    len_in = 5'd3; dir = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({head, tail, led_mask, busy, step} !== {5'd2, 5'd0, 24'h000007, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL start_load: got h=%0d t=%0d m=%h b=%b s=%b expected h=2 t=0 m=000007 b=1 s=0",
                         head, tail, led_mask, busy, step);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL start_run: got %h expected %h", act, exp_vec()); end
    end
    n_tests++;
    if ({step, head, tail, led_mask} !== {1'b1, 5'd3, 5'd1, 24'h00000E}) begin
      n_fail++; $display("FAIL first_step: got s=%b h=%0d t=%0d m=%h expected s=1 h=3 t=1 m=00000e",
                         step, head, tail, led_mask);
    end
  endtask

  task automatic test_wraps();
    for (int i = 0; i < 200 && head !== 5'd23; i++) begin
      cyc();
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL fwd_run: got %h expected %h", act, exp_vec()); end
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (step === 1'b1) break;
    end
    n_tests++;
    if ({head, tail, led_mask, step, lap} !== {5'd0, 5'd22, 24'hC00001, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL fwd_wrap: got h=%0d t=%0d m=%h s=%b l=%b expected h=0 t=22 m=c00001 s=1 l=1",
                         head, tail, led_mask, step, lap);
    end
    dir = 1'b1;
    cyc();
    n_tests++;
    if ({step, lap} !== 2'b00) begin n_fail++; $display("FAIL lap_width: got s=%b l=%b expected 00", step, lap); end
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (step === 1'b1) break;
    end
    n_tests++;
    if ({head, tail, led_mask, step, lap} !== {5'd23, 5'd1, 24'h800003, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL rev_wrap: got h=%0d t=%0d m=%h s=%b l=%b expected h=23 t=1 m=800003 s=1 l=1",
                         head, tail, led_mask, step, lap);
    end
    n_tests++;
    if (act !== exp_vec()) begin n_fail++; $display("FAIL rev_model: got %h expected %h", act, exp_vec()); end
  endtask

  task automatic test_pause_resume();
    cyc(); cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if ({step, busy} !== 2'b01 || act !== exp_vec()) begin
        n_fail++; $display("FAIL hold: got %h expected %h", act, exp_vec());
      end
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    n_tests++;
    if ({step, busy} !== 2'b01) begin n_fail++; $display("FAIL resume_early: got s=%b b=%b expected s=0 b=1", step, busy); end
    cyc();
    n_tests++;
    if ({step, busy} !== 2'b11 || act !== exp_vec()) begin
      n_fail++; $display("FAIL resume_step: got %h expected %h", act, exp_vec());
    end
    stop = 1'b1;
    cyc(); cyc();
    stop = 1'b0;
    n_tests++;
    if (act !== 37'd0) begin n_fail++; $display("FAIL hold_clear: got %h expected 0", act); end
  endtask

  task automatic test_boundaries();
    len_in = 5'd0; dir = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    n_tests++;
    if ({head, tail, led_mask} !== {5'd0, 5'd0, 24'h000001}) begin
      n_fail++; $display("FAIL len0: got h=%0d t=%0d m=%h expected h=0 t=0 m=000001", head, tail, led_mask);
    end
    for (int i = 0; i < 4; i++) cyc();
    n_tests++;
    if ($countones(led_mask) != 1 || act !== exp_vec()) begin
      n_fail++; $display("FAIL len0_step: got %h expected %h", act, exp_vec());
    end
    stop = 1'b1; cyc(); cyc(); stop = 1'b0;
    len_in = 5'd31; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      n_tests++;
      if (led_mask !== 24'hFFFFFF || act !== exp_vec()) begin
        n_fail++; $display("FAIL len_full: got %h expected %h", act, exp_vec());
      end
      cyc();
    end
    stop = 1'b1; cyc(); cyc();
    start = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    n_tests++;
    if (act !== 37'd0) begin n_fail++; $display("FAIL start_stop_idle: got %h expected 0", act); end
    len_in = 5'd5; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_tests++;
    if (act !== 37'd0) begin n_fail++; $display("FAIL rst_mid_run: got %h expected 0", act); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 79) == 0);
      stop   = ($urandom_range(0, 9) == 0);
      start  = ($urandom_range(0, 3) == 0);
      len_in = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 11) == 0) dir = ~dir;
      cyc();
      n_tests++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, act, exp_vec()); end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_forward();
    test_wraps();
    test_pause_resume();
    test_boundaries();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Controller that sequences the LED-snake position datapath.
- Generates periodic step ticks from the system clock and advances a head position modulo N in the selected direction.
- Derives the tail from the latched snake length and drives the N-bit LED mask.
- Provides start/pause/stop sequencing and a lap pulse on every wrap of the head position.

Parameters:
- N, 24, number of LED positions; head and tail range 0..N-1.
- POS_W, 5, width of position and length fields; requires 2**POS_W >= N.
- STEP_DIV, 1000000, clock cycles per snake step; must be >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  level; start from IDLE or resume from HOLD.
- stop  in  1  level; pause from RUN or clear from HOLD.
- dir  in  1  0 = forward (increment), 1 = reverse (decrement).
- len_in  in  POS_W  requested snake length; latched only on IDLE->RUN.
- head  out  POS_W  current head position.
- tail  out  POS_W  current tail position.
- led_mask  out  N  one bit per LED, set for every position from tail to head inclusive, circular.
- step  out  1  one-cycle pulse, coincident with the new head value.
- lap  out  1  one-cycle pulse on a head wrap; always coincident with step.
- busy  out  1  high in RUN and in HOLD.

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - head, tail, led_mask, step, lap, busy and the prescaler all clear to 0.
  - Reset mid-run aborts immediately; there is no drain.
- FSM states: IDLE, RUN, HOLD.
- stop has priority over start when both are high in the same cycle.
- IDLE:
  - start=1 and stop=0 moves to RUN.
  - On that edge: latch len = clamp(len_in, 1..N), so 0 becomes 1 and values above N become N.
  - On that edge: head = len-1, tail = 0, led_mask = bits 0..len-1, prescaler = 0, busy = 1.
  - Any other input combination: remain in IDLE with all outputs at 0.
- RUN:
  - The prescaler increments every cycle.
  - When it equals STEP_DIV-1, it returns to 0 on the next edge. On that same edge head, tail and led_mask update and step=1 for one cycle.
  - Step period is exactly STEP_DIV cycles. The first step comes STEP_DIV cycles after the start edge.
  - Forward step: head = (head+1) mod N; lap=1 when the old head was N-1.
  - Reverse step: head = (head-1) mod N; lap=1 when the old head was 0.
  - dir is sampled only at a step edge. A direction change takes effect at the next step and swaps which side of head the body lies.
  - stop=1 moves to HOLD. The prescaler, head, tail and mask freeze.
  - If stop coincides with a step cycle, the step is suppressed.
- HOLD:
  - start=1 and stop=0 moves to RUN. The prescaler resumes from its frozen value and len is not reloaded.
  - stop=1 moves to IDLE and clears all outputs.
  - busy stays 1 while in HOLD.
- Tail:
  - Forward: tail = (head - (len-1)) mod N.
  - Reverse: tail = (head + (len-1)) mod N.
  - Computed with POS_W+1-bit arithmetic and explicit modulo correction, never relying on power-of-two wrap.
- led_mask: bit i is set iff i lies on the circular path from tail to head inclusive, in the direction of travel. With len = N all bits are set.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Package snake_pkg holds:
  - the state typedef (IDLE/RUN/HOLD, 2-bit encoding);
  - default N and POS_W constants;
  - a function mod_add(pos, delta, n) shared by the head and tail logic.
- One sub-module, step_prescaler, with ports clk, rst, en, clr and tick. It counts 0..STEP_DIV-1 while en is high, holds while en is low, and zeroes on clr.
- Mask generation and the FSM remain in snake_step_ctrl.

Test Plan (N=24, STEP_DIV=4):
- Reset: assert rst for 2 cycles, release.
  - Required: head=0, tail=0, led_mask=0x000000, step=lap=busy=0; start low keeps IDLE.
- Start forward: len_in=3, dir=0, start pulse.
  - Next cycle: head=2, tail=0, mask=0x000007, busy=1.
  - 4 cycles later: step=1, head=3, tail=1, mask=0x00000E.
- Forward wrap: run until head=23, then next step.
  - Required: head=0, tail=22, mask=0xC00001, step=lap=1 for exactly one cycle.
- Reverse wrap: head=0, len=3, dir=1, next step.
  - Required: head=23, lap=1, tail=1, mask=0x800003.
- Pause/resume: stop 2 cycles after a step, hold 10 cycles, then start.
  - Required: no step during HOLD; next step 2 cycles after resume; busy=1 throughout.
  - Then stop in HOLD: IDLE, all outputs 0.
- Boundaries:
  - len_in=0 gives a single-bit mask.
  - len_in=31 gives mask=0xFFFFFF, constant across steps.
  - start and stop together in IDLE: stays IDLE.
  - rst mid-RUN: all outputs 0 on the next cycle.
